// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } meter_state_t;

  // Number of edge-less ticks that forces a timeout publish.
  function automatic int unsigned timeout_ticks(input int unsigned res_bits);
    return (32'd1 << (res_bits + 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_meter_bcd.sv
// Binary to three-digit BCD converter with a load-qualified output register.
// Only instantiated when PWM_METER_BCD_EN is defined.
module pwm_meter_bcd
  import pwm_meter_pkg::*;
#(
  parameter int unsigned RESOLUTION_BITS = 8
) (
  input  logic                       clk_top,
  input  logic                       rst_top,
  input  logic                       load,
  input  logic [RESOLUTION_BITS-1:0] bin,
  output logic [3:0]                 hundreds,
  output logic [3:0]                 tens,
  output logic [3:0]                 units
);

  localparam int unsigned RW = RESOLUTION_BITS;
  localparam int unsigned SW = RW + 12;

  logic [SW-1:0] sr;

  // Shift-and-add-3 conversion, fully unrolled.
  always_comb begin
    sr = {12'd0, bin};
    for (int i = 0; i < int'(RW); i++) begin
      if (sr[RW +: 4] >= 4'd5)      sr[RW +: 4]      = sr[RW +: 4] + 4'd3;
      if (sr[RW + 4 +: 4] >= 4'd5)  sr[RW + 4 +: 4]  = sr[RW + 4 +: 4] + 4'd3;
      if (sr[RW + 8 +: 4] >= 4'd5)  sr[RW + 8 +: 4]  = sr[RW + 8 +: 4] + 4'd3;
      sr = {sr[SW-2:0], 1'b0};
    end
  end

  // Capture the digits alongside the binary result.
  always_ff @(posedge clk_top) begin
    if (rst_top) begin
      hundreds <= 4'd0;
      tens     <= 4'd0;
      units    <= 4'd0;
    end else if (load) begin
      hundreds <= sr[RW + 8 +: 4];
      tens     <= sr[RW + 4 +: 4];
      units    <= sr[RW +: 4];
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty/period meter: synchronizes pwm_in, samples it on prescaler ticks
// and measures high time and period in ticks, with an edge-less timeout.
// Define PWM_METER_BCD_EN to add BCD digit outputs of duty_out.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned FRECUENCY_BITS  = 3,
  parameter int unsigned RESOLUTION_BITS = 8
) (
  input  logic                       clk_top,
  input  logic                       rst_top,
  input  logic                       pwm_in,
  output logic [RESOLUTION_BITS-1:0] duty_out,
  output logic [RESOLUTION_BITS:0]   period_out,
  output logic                       rdy_top,
  output logic                       stuck
`ifdef PWM_METER_BCD_EN
  ,
  output logic [3:0]                 fdig_top,
  output logic [3:0]                 sdig_top,
  output logic [3:0]                 tdig_top
`endif
);

  localparam int unsigned RW    = RESOLUTION_BITS;
  localparam int unsigned PW    = RESOLUTION_BITS + 1;
  localparam int unsigned DIV_W = (FRECUENCY_BITS > 0) ? FRECUENCY_BITS : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'((64'd1 << FRECUENCY_BITS) - 64'd1);
  localparam logic [PW-1:0]    IDLE_SAT  = PW'(timeout_ticks(RW));
  localparam logic [PW-1:0]    IDLE_LAST = PW'(timeout_ticks(RW) - 32'd1);
  localparam logic [RW-1:0]    HIGH_MAX  = {RW{1'b1}};
  localparam logic [PW-1:0]    PER_MAX   = {PW{1'b1}};

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             sync_a;
  logic             sync_b;
  logic             sample;
  logic             rise;
  logic             fall;
  logic             timeout;
  logic             publish;
  logic [RW-1:0]    pub_duty;
  meter_state_t     state;
  logic [RW-1:0]    high_cnt;
  logic [PW-1:0]    per_cnt;
  logic [PW-1:0]    idle_cnt;

  assign tick     = (div_cnt == DIV_LAST);
  assign rise     = tick & sync_b & ~sample;
  assign fall     = tick & ~sync_b & sample;
  // Any edge clears the idle count, so a rising edge always beats the timeout.
  assign timeout  = tick & ~rise & ~fall & (idle_cnt == IDLE_LAST);
  assign publish  = timeout | (rise & (state == LOW));
  assign pub_duty = timeout ? (sync_b ? HIGH_MAX : '0) : high_cnt;

  // Prescaler, 2-FF synchronizer and per-tick sample of pwm_in.
  always_ff @(posedge clk_top) begin
    if (rst_top) begin
      div_cnt <= '0;
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      sample  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      sync_a  <= pwm_in;
      sync_b  <= sync_a;
      if (tick) sample <= sync_b;
    end
  end

  // Measurement FSM, counters and registered result.
  always_ff @(posedge clk_top) begin
    if (rst_top) begin
      state      <= WAIT_RISE;
      high_cnt   <= '0;
      per_cnt    <= '0;
      idle_cnt   <= '0;
      duty_out   <= '0;
      period_out <= '0;
      rdy_top    <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      rdy_top <= publish;
      if (publish) begin
        duty_out   <= pub_duty;
        period_out <= timeout ? '0 : per_cnt;
        stuck      <= timeout;
      end
      if (tick) begin
        if (rise | fall)            idle_cnt <= '0;
        else if (idle_cnt != IDLE_SAT) idle_cnt <= idle_cnt + PW'(1);

        if (timeout) begin
          state <= WAIT_RISE;
        end else begin
          case (state)
            WAIT_RISE: begin
              if (rise) begin
                state    <= HIGH;
                high_cnt <= RW'(1);
                per_cnt  <= PW'(1);
              end
            end
            HIGH: begin
              per_cnt <= (per_cnt == PER_MAX) ? per_cnt : per_cnt + PW'(1);
              if (fall) state <= LOW;
              else high_cnt <= (high_cnt == HIGH_MAX) ? high_cnt : high_cnt + RW'(1);
            end
            LOW: begin
              if (rise) begin
                state    <= HIGH;
                high_cnt <= RW'(1);
                per_cnt  <= PW'(1);
              end else begin
                per_cnt <= (per_cnt == PER_MAX) ? per_cnt : per_cnt + PW'(1);
              end
            end
            default: state <= WAIT_RISE;
          endcase
        end
      end
    end
  end

`ifdef PWM_METER_BCD_EN
  pwm_meter_bcd #(
    .RESOLUTION_BITS(RW)
  ) u_bcd (
    .clk_top  (clk_top),
    .rst_top  (rst_top),
    .load     (publish),
    .bin      (pub_duty),
    .hundreds (fdig_top),
    .tens     (sdig_top),
    .units    (tdig_top)
  );
`endif

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 Parameter FRECUENCY_BITS, default 3: the prescaler divides clk_top by 2^FRECUENCY_BITS to produce the sample tick.
REQ-002 Parameter RESOLUTION_BITS, default 8: width of the duty_out result.
REQ-003 Port clk_top  input  1: single clock for the whole block.
REQ-004 Port rst_top  input  1: reset, synchronous and active-high.
REQ-005 Port pwm_in  input  1: asynchronous PWM signal under measurement.
REQ-006 Port duty_out  output  RESOLUTION_BITS: measured high time, in ticks.
REQ-007 Port period_out  output  RESOLUTION_BITS+1: measured period, in ticks.
REQ-008 Port rdy_top  output  1: one-clk_top pulse that qualifies a new duty_out/period_out pair.
REQ-009 Port stuck  output  1: high while the last result came from a timeout.
REQ-010 Ports fdig_top, sdig_top, tdig_top  output  4 each: hundreds, tens and units BCD digits of duty_out; present only under REQ-024.

Function
REQ-011 pwm_in shall pass through a 2-FF synchronizer and be sampled only on prescaler ticks; a tick is one clk_top cycle every 2^FRECUENCY_BITS cycles.
REQ-012 A rising or falling edge shall be detected by comparing the current tick sample with the previous tick sample.
REQ-013 The FSM shall have the states WAIT_RISE, HIGH, LOW.
- Reset enters WAIT_RISE.
- WAIT_RISE -> HIGH on a rising edge; the high and period counters load 1.
- HIGH -> LOW on a falling edge.
- LOW -> HIGH on a rising edge; the result is published and the counters reload 1.
REQ-014 The high counter shall increment on each tick in HIGH, and saturate at 2^RESOLUTION_BITS-1.
REQ-015 The period counter shall increment on each tick in HIGH or LOW, and saturate at 2^(RESOLUTION_BITS+1)-1.
REQ-016 On publish:
- duty_out takes the high count.
- period_out takes the period count.
- rdy_top pulses on the clk_top cycle after the tick that detected the rising edge.
REQ-017 Timeout: if no edge occurs for 2^(RESOLUTION_BITS+1)-1 consecutive ticks in any state, the block shall publish once, then return to WAIT_RISE.
- duty_out = all ones if the sample is high, else 0.
- period_out = 0.
- stuck = 1.
- rdy_top pulses.
REQ-018 stuck shall clear on the next normal publish.
REQ-019 If a rising edge and a timeout occur on the same tick, the edge shall win.
REQ-020 Outputs shall hold between publishes; a single-tick glitch shall be measured as-is, with no filtering.

Reset
REQ-021 While rst_top is high, the following shall all be 0: duty_out, period_out, rdy_top, stuck, the BCD digits, all counters, the prescaler and the synchronizer.
REQ-022 Reset asserted mid-measurement shall discard the partial count and produce no rdy_top pulse.
REQ-023 The first publish after reset shall require a full rising-falling-rising sequence, or a timeout.

Configuration
REQ-024 Macro PWM_METER_BCD_EN shall control the BCD digit outputs.
- Defined: fdig_top/sdig_top/tdig_top exist and update together with duty_out, or at most RESOLUTION_BITS+2 clk_top cycles later.
- Undefined: the ports and the converter are absent.
- When the converter is iterative, rdy_top shall be delayed so that it qualifies duty_out, period_out and the digits together.

Structure
REQ-025 Package pwm_meter_pkg shall hold the FSM state typedef (WAIT_RISE, HIGH, LOW) and the timeout-count constant function.
REQ-026 One sub-module, pwm_meter_bcd, shall be used: binary-to-BCD conversion, instantiated only under PWM_METER_BCD_EN.

Verification
REQ-027 Defaults, pwm_in 64 ticks high / 192 ticks low, repeated -> second and later rdy_top pulses show duty_out=64, period_out=256, stuck=0; with BCD: 0/6/4.
REQ-028 pwm_in held 0 after reset -> after 511 ticks, rdy_top pulses with duty_out=0, period_out=0, stuck=1.
REQ-029 pwm_in held 1 -> timeout publish with duty_out=255, stuck=1; then 10 high / 20 low -> stuck=0, duty_out=10, period_out=30.
REQ-030 High time of 300 ticks, period 400 -> duty_out=255 (saturated), period_out=400.
REQ-031 rst_top pulsed mid-HIGH during a 64/256 stream -> no rdy_top until a full new period; the next result is 64/256.
REQ-032 Edge and timeout on the same tick -> normal publish, stuck=0.
